// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor
// Conflict-monitor stage between the 4-way traffic controller FSM and the lamp drivers.
// Every cycle the four 2-bit controller codes are checked for unsafe conditions. While no
// fault is present, the lamps are a registered one-hot decode of the codes. When a check
// fails, the first fault is latched and the lamps are forced to solid all-red. The block
// then flashes red until a clear request arrives while the inputs are safe.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   NS/EW/SN/WE_light  controller codes: 00 RED, 01 YELLOW, 10 GREEN, 11 invalid
//   clr_fault    single-cycle fault-clear request (honoured only in the flash state)
//   NS/EW/SN/WE_lamp   one-hot {R,Y,G} lamp drives; 000 = all lamps off
//   fault        high in any fault state
//   fault_code   latched cause: 0 none, 1 conflict, 2 invalid, 3 green-to-red skip,
//                4 short yellow
//   fault_count  (only with TRAFFIC_FAULT_COUNT_EN) saturating count of faults entered
//
// Optional feature macro: TRAFFIC_FAULT_COUNT_EN adds the fault_count output.

module traffic_light_safety_monitor #(
    parameter int unsigned MIN_YELLOW     = 3,
    parameter int unsigned ALL_RED_CYCLES = 4,
    parameter int unsigned FLASH_HALF     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] NS_light,
    input  logic [1:0] EW_light,
    input  logic [1:0] SN_light,
    input  logic [1:0] WE_light,
    input  logic       clr_fault,
    output logic [2:0] NS_lamp,
    output logic [2:0] EW_lamp,
    output logic [2:0] SN_lamp,
    output logic [2:0] WE_lamp,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef TRAFFIC_FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam logic [1:0] CodeRed    = 2'b00;
    localparam logic [1:0] CodeYellow = 2'b01;
    localparam logic [1:0] CodeGreen  = 2'b10;
    localparam logic [1:0] CodeBad    = 2'b11;

    localparam logic [2:0] LampRed = 3'b100;
    localparam logic [2:0] LampOff = 3'b000;

    localparam int unsigned YW        = $clog2(MIN_YELLOW + 1);
    localparam int unsigned TIMER_MAX = (ALL_RED_CYCLES > FLASH_HALF) ? ALL_RED_CYCLES
                                                                      : FLASH_HALF;
    localparam int unsigned TW        = $clog2(TIMER_MAX + 1);

    typedef enum logic [1:0] {StNormal, StFaultRed, StFlash} state_e;

    state_e          state;
    logic [1:0]      cur  [4];  // index order: NS, EW, SN, WE
    logic [1:0]      prev [4];
    logic [YW-1:0]   ycnt [4];
    logic [TW-1:0]   timer;

    logic            conflict, invalid, skip, short_yel;
    logic [2:0]      det_code;
    logic            det_fault;

    assign cur[0] = NS_light;
    assign cur[1] = EW_light;
    assign cur[2] = SN_light;
    assign cur[3] = WE_light;

    function automatic logic [2:0] decode(input logic [1:0] code);
        case (code)
            CodeYellow: decode = 3'b010;
            CodeGreen:  decode = 3'b001;
            default:    decode = LampRed;
        endcase
    endfunction

    // Axis A = {NS, SN}, axis B = {EW, WE}; both axes showing non-red is a conflict.
    always_comb begin
        conflict  = ((cur[0] != CodeRed) || (cur[2] != CodeRed)) &&
                    ((cur[1] != CodeRed) || (cur[3] != CodeRed));
        invalid   = 1'b0;
        skip      = 1'b0;
        short_yel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cur[i] == CodeBad) invalid = 1'b1;
            if (prev[i] == CodeGreen && cur[i] == CodeRed) skip = 1'b1;
            // Uses the yellow count before this cycle's update.
            if (prev[i] == CodeYellow && cur[i] == CodeRed && ycnt[i] < YW'(MIN_YELLOW))
                short_yel = 1'b1;
        end
        if (conflict)       det_code = 3'd1;
        else if (invalid)   det_code = 3'd2;
        else if (skip)      det_code = 3'd3;
        else if (short_yel) det_code = 3'd4;
        else                det_code = 3'd0;
        det_fault = (det_code != 3'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StNormal;
            NS_lamp    <= LampRed;
            EW_lamp    <= LampRed;
            SN_lamp    <= LampRed;
            WE_lamp    <= LampRed;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            timer      <= '0;
            for (int i = 0; i < 4; i++) begin
                prev[i] <= CodeRed;
                ycnt[i] <= '0;
            end
`ifdef TRAFFIC_FAULT_COUNT_EN
            fault_count <= 8'd0;
`endif
        end else begin
            // History tracking runs in every state.
            for (int i = 0; i < 4; i++) begin
                prev[i] <= cur[i];
                if (cur[i] != CodeYellow)            ycnt[i] <= '0;
                else if (ycnt[i] < YW'(MIN_YELLOW))  ycnt[i] <= ycnt[i] + 1'b1;
            end

            case (state)
                StNormal: begin
                    if (det_fault) begin
                        state      <= StFaultRed;
                        fault      <= 1'b1;
                        fault_code <= det_code;
                        timer      <= '0;
                        NS_lamp    <= LampRed;
                        EW_lamp    <= LampRed;
                        SN_lamp    <= LampRed;
                        WE_lamp    <= LampRed;
`ifdef TRAFFIC_FAULT_COUNT_EN
                        if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
`endif
                    end else begin
                        NS_lamp <= decode(NS_light);
                        EW_lamp <= decode(EW_light);
                        SN_lamp <= decode(SN_light);
                        WE_lamp <= decode(WE_light);
                    end
                end
                StFaultRed: begin
                    if (timer == TW'(ALL_RED_CYCLES - 1)) begin
                        state <= StFlash;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StFlash: begin
                    if (clr_fault && !det_fault) begin
                        state      <= StNormal;
                        fault      <= 1'b0;
                        fault_code <= 3'd0;
                        timer      <= '0;
                        NS_lamp    <= decode(NS_light);
                        EW_lamp    <= decode(EW_light);
                        SN_lamp    <= decode(SN_light);
                        WE_lamp    <= decode(WE_light);
                    end else if (timer == TW'(FLASH_HALF - 1)) begin
                        timer <= '0;
                        // All lamps move together, so NS_lamp carries the flash phase.
                        NS_lamp <= (NS_lamp == LampRed) ? LampOff : LampRed;
                        EW_lamp <= (NS_lamp == LampRed) ? LampOff : LampRed;
                        SN_lamp <= (NS_lamp == LampRed) ? LampOff : LampRed;
                        WE_lamp <= (NS_lamp == LampRed) ? LampOff : LampRed;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= StNormal;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Directed bench for traffic_light_safety_monitor (default parameters 3/4/5).
module tb_traffic_light_safety_monitor;

    localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, X = 2'b11;
    localparam logic [11:0] ALLRED = 12'b100_100_100_100;
    localparam logic [11:0] ALLOFF = 12'b000_000_000_000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ns, ew, sn, we;
    logic       clr;
    logic [2:0] ns_lamp, ew_lamp, sn_lamp, we_lamp;
    logic       fault;
    logic [2:0] fault_code;
`ifdef TRAFFIC_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_safety_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .NS_light   (ns),
        .EW_light   (ew),
        .SN_light   (sn),
        .WE_light   (we),
        .clr_fault  (clr),
        .NS_lamp    (ns_lamp),
        .EW_lamp    (ew_lamp),
        .SN_lamp    (sn_lamp),
        .WE_lamp    (we_lamp),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef TRAFFIC_FAULT_COUNT_EN
        ,
        .fault_count(fault_count)
`endif
    );

    wire [11:0] lamps = {ns_lamp, ew_lamp, sn_lamp, we_lamp};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lights(input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] d);
        ns = a; ew = b; sn = c; we = d;
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From the first fault cycle (k=1): all red, wait into FLASH, then clear.
    task automatic clear_from_fault(input string tag);
        set_lights(R, R, R, R);
        tick(4);            // k=5: first FLASH cycle
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk({tag, "_cleared"}, {29'd0, fault, fault_code}, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        set_lights(R, R, R, R);
        #12;
        chk("reset_lamps", lamps, ALLRED);
        chk("reset_fault", {fault, fault_code}, 4'h0);
`ifdef TRAFFIC_FAULT_COUNT_EN
        chk("reset_count", fault_count, 8'd0);
`endif
        reset = 1'b1;
        tick();

        // Normal cycle on axis A.
        set_lights(G, R, G, R);
        tick();
        chk("norm_green", lamps, 12'b001_100_001_100);
        tick(4);
        set_lights(Y, R, Y, R);
        tick();
        chk("norm_yellow", ns_lamp, 3'b010);
        tick(2);
        set_lights(R, R, R, R);
        tick();
        chk("norm_red", lamps, ALLRED);
        chk("norm_nofault", {fault, fault_code}, 4'h0);

        // Conflict: NS and EW green together.
        set_lights(G, G, R, R);
        tick();                                       // k=1
        chk("conf_code", {fault, fault_code}, {1'b1, 3'd1});
        chk("conf_lamps", lamps, ALLRED);
`ifdef TRAFFIC_FAULT_COUNT_EN
        chk("conf_count", fault_count, 8'd1);
`endif
        set_lights(R, R, R, R);                       // also a skip, which must not re-latch
        clr = 1'b1;
        tick();                                       // k=2, clear ignored in FAULT_RED
        clr = 1'b0;
        chk("faultred_clr_ignored", {fault, fault_code}, {1'b1, 3'd1});
`ifdef TRAFFIC_FAULT_COUNT_EN
        chk("faultred_no_recount", fault_count, 8'd1);
`endif
        tick(2);                                      // k=4
        chk("faultred_end", lamps, ALLRED);
        tick(5);                                      // k=9, last flash-on cycle
        chk("flash_on_last", lamps, ALLRED);
        tick();                                       // k=10
        chk("flash_off_first", lamps, ALLOFF);
        tick(4);                                      // k=14
        chk("flash_off_last", lamps, ALLOFF);
        tick();                                       // k=15
        chk("flash_on_again", lamps, ALLRED);

        // Clear refused while an input is invalid.
        set_lights(X, R, R, R);
        clr = 1'b1;
        tick();                                       // k=16
        chk("clr_refused", {fault, fault_code}, {1'b1, 3'd1});
        chk("clr_refused_lamps", lamps, ALLRED);
        set_lights(R, R, R, R);
        tick();
        clr = 1'b0;
        chk("clr_ok", {fault, fault_code}, 4'h0);
        chk("clr_ok_lamps", lamps, ALLRED);

        // Green-to-red skip on WE.
        set_lights(R, R, R, G);
        tick();
        chk("we_green", we_lamp, 3'b001);
        set_lights(R, R, R, R);
        tick();
        chk("skip_code", {fault, fault_code}, {1'b1, 3'd3});
        clear_from_fault("skip");

        // Short yellow (two cycles) on WE.
        set_lights(R, R, R, G);
        tick();
        set_lights(R, R, R, Y);
        tick(2);
        chk("short_yel_pending", fault, 1'b0);
        set_lights(R, R, R, R);
        tick();
        chk("short_yel_code", {fault, fault_code}, {1'b1, 3'd4});
        clear_from_fault("short");

        // Invalid code on EW.
        set_lights(R, X, R, R);
        tick();
        chk("invalid_code", {fault, fault_code}, {1'b1, 3'd2});
        clear_from_fault("invalid");

        // Conflict outranks invalid when both fire.
        set_lights(G, X, R, R);
        tick();
        chk("priority_code", fault_code, 3'd1);
`ifdef TRAFFIC_FAULT_COUNT_EN
        chk("count_five", fault_count, 8'd5);
`endif
        clear_from_fault("priority");

        // Reset mid-fault during the flash-off phase, with no clock edge.
        set_lights(G, G, R, R);
        tick();
        set_lights(R, R, R, R);
        tick(9);                                      // k=10
        chk("pre_reset_off", lamps, ALLOFF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_lamps", lamps, ALLRED);
        chk("async_reset_fault", {fault, fault_code}, 4'h0);
`ifdef TRAFFIC_FAULT_COUNT_EN
        chk("async_reset_count", fault_count, 8'd0);
`endif
        #5;
        reset = 1'b1;
        set_lights(R, G, R, G);
        tick();
        chk("post_reset_normal", lamps, 12'b100_001_100_001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_safety_monitor.md
Name: traffic_light_safety_monitor

Overview:
- Sits directly downstream of the 4-way traffic controller FSM.
- Consumes its four 2-bit light codes, checks them every cycle for unsafe conditions, and drives the physical one-hot lamp outputs {R,Y,G}.
- On any fault it latches the fault, forces all-red, then enters red-flash mode until cleared. This is the conflict-monitor stage between the controller and the lamp drivers.

Parameters:
- MIN_YELLOW, 3: minimum consecutive YELLOW cycles required before RED on any direction.
- ALL_RED_CYCLES, 4: number of cycles of solid all-red after a fault is detected.
- FLASH_HALF, 5: half-period of the red flash, in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- NS_light  in  2  controller code: 00 RED, 01 YELLOW, 10 GREEN, 11 invalid.
- EW_light  in  2  same encoding.
- SN_light  in  2  same encoding.
- WE_light  in  2  same encoding.
- clr_fault  in  1  single-cycle fault-clear request.
- NS_lamp  out  3  one-hot {R,Y,G}; 000 means all lamps off.
- EW_lamp  out  3  same.
- SN_lamp  out  3  same.
- WE_lamp  out  3  same.
- fault  out  1  high in any fault state.
- fault_code  out  3  latched cause: 0 none, 1 conflict, 2 invalid code, 3 green-to-red skip, 4 short yellow.

Behaviour:
- Reset (reset=0, async): state NORMAL; all lamps 3'b100 (red); fault=0; fault_code=0; per-direction previous-code registers = RED; yellow counters = 0; flash counter = 0.
- Axis groups: A={NS,SN}, B={EW,WE}.
- Per-cycle checks on the current inputs, in priority order (lowest code wins when several fire together):
  - (1) conflict: any A light non-RED while any B light is non-RED.
  - (2) invalid: any code equals 11.
  - (3) skip: prev=GREEN and cur=RED on any direction.
  - (4) short yellow: prev=YELLOW, cur=RED, and that direction's yellow count < MIN_YELLOW.
- Yellow counter (per direction):
  - Increments each cycle the input is YELLOW, saturating at MIN_YELLOW.
  - Clears when the input is not YELLOW.
  - The check in (4) uses the count before this cycle's update.
- Previous-code registers update every cycle in every state.
- NORMAL state:
  - Lamps are registered decodes of the inputs (1-cycle latency): RED→100, YELLOW→010, GREEN→001.
  - A detected fault in cycle N: in cycle N+1, state = FAULT_RED, fault=1, fault_code latched, all lamps 100. The offending code is never passed to the lamps.
- FAULT_RED state:
  - All lamps 100 for exactly ALL_RED_CYCLES cycles, then FLASH.
  - clr_fault is ignored.
  - New faults do not change the latched fault_code.
- FLASH state:
  - All four lamps equal; they alternate 100 and 000 every FLASH_HALF cycles, starting with 100 on entry.
  - clr_fault=1 in a cycle where the current inputs pass all four checks: next cycle state = NORMAL, fault=0, fault_code=0, lamps = decode of the inputs in that cycle.
  - clr_fault=1 while any check fails: ignored, remain in FLASH.
- Reset asserted mid-fault: immediate return to the reset values; the latched fault is lost.
- All counters are wide enough for their parameter ($clog2(param+1)) and never wrap.

Optional Feature:
- Macro: TRAFFIC_FAULT_COUNT_EN.
- When defined:
  - Adds output fault_count [7:0].
  - Increments on each NORMAL→FAULT_RED transition and saturates at 255.
  - Reset value 0; it is not cleared by clr_fault.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Normal cycle: NS=SN=GREEN 5 cycles, YELLOW 3 cycles, RED; EW=WE=RED throughout → NS_lamp follows with 1-cycle lag (001, 010, 100); fault stays 0.
- Conflict: NS=GREEN and EW=GREEN in the same cycle → next cycle fault=1, fault_code=1, all lamps 100 for 4 cycles; then flash 100/000 with 5-cycle halves.
- Skip yellow: WE goes GREEN→RED directly → fault_code=3. With YELLOW held only 2 cycles before RED → fault_code=4. With EW=11 → fault_code=2.
- Clear: in FLASH, clr_fault=1 while inputs are all RED → NORMAL next cycle, lamps 100, fault=0. Repeat with an input =11 → clr_fault is ignored and the block stays in FLASH. clr_fault during FAULT_RED → ignored.
- Reset mid-fault: drive reset=0 asynchronously during FLASH → outputs return to their reset values immediately without waiting for a clock edge.
- With TRAFFIC_FAULT_COUNT_EN defined: three faults with clears between them → fault_count=3. A second fault arriving during FAULT_RED does not increment it.
